// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single shared mem_system port.
// Latency: request-to-done is 1 cycle plus memory latency; one IDLE cycle between grants.
// Backpressure: requesters stall until their done pulse. Define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_done,
    output logic        d_done,
    output logic [15:0] i_rdata,
    output logic [15:0] d_rdata,
    output logic        i_stall,
    output logic        d_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_err,
    output logic        err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0]  state;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        lat_wr;
    logic        dropped;
    logic        pick_d;
    logic        in_gi;
    logic        in_gd;
    logic        act;
    logic        gnt_req;

`ifdef MEM_ARB_RR_EN
    logic rr_d;

    always_comb pick_d = d_req & (~i_req | rr_d);

    // Pointer names the requester that wins the next tie: the one not granted last.
    always_ff @(posedge clk) begin
        if (rst)
            rr_d <= 1'b1;
        else if (state == IDLE && (i_req || d_req))
            rr_d <= ~pick_d;
    end
`else
    always_comb pick_d = d_req;
`endif

    always_comb begin
        in_gi   = (state == GRANT_I);
        in_gd   = (state == GRANT_D);
        act     = (in_gi | in_gd) & ~rst;
        gnt_req = in_gi ? i_req : d_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_addr  <= 16'h0;
            lat_wdata <= 16'h0;
            lat_wr    <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dropped <= 1'b0;
                    if (i_req || d_req) begin
                        lat_addr  <= pick_d ? d_addr : i_addr;
                        lat_wdata <= pick_d ? d_wdata : 16'h0;
                        lat_wr    <= pick_d & d_wr;
                        state     <= pick_d ? GRANT_D : GRANT_I;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_done)
                        state <= IDLE;
                    else if (!gnt_req)
                        dropped <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so nothing leaks while a reset is being applied.
    always_comb begin
        mem_rd    = act & ~lat_wr;
        mem_wr    = act & lat_wr;
        mem_addr  = rst ? 16'h0 : lat_addr;
        mem_wdata = rst ? 16'h0 : lat_wdata;
        i_done    = ~rst & in_gi & mem_done;
        d_done    = ~rst & in_gd & mem_done;
        i_rdata   = (i_done & ~lat_wr) ? mem_rdata : 16'h0;
        d_rdata   = (d_done & ~lat_wr) ? mem_rdata : 16'h0;
        i_stall   = ~rst & i_req & ~i_done;
        d_stall   = ~rst & d_req & ~d_done;
        // A dropped request flags once; the transaction still runs to completion.
        err       = act & (mem_err | (~gnt_req & ~mem_done & ~dropped));
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 i_req  input  1  fetch-side read request, held high until i_done.
REQ-004 i_addr  input  16  fetch read address.
REQ-005 d_req  input  1  data-side request, held high until d_done.
REQ-006 d_wr  input  1  data-side op: 1 write, 0 read.
REQ-007 d_addr  input  16  data-side address.
REQ-008 d_wdata  input  16  data-side write data.
REQ-009 i_done, d_done  output  1 each  one-cycle completion pulse per requester.
REQ-010 i_rdata, d_rdata  output  16 each  read data, valid only in the matching done cycle, else 0.
REQ-011 i_stall, d_stall  output  1 each  requester pending and not done this cycle.
REQ-012 mem_addr, mem_wdata  output  16 each  to shared mem_system Addr/DataIn.
REQ-013 mem_rd, mem_wr  output  1 each  to mem_system Rd/Wr.
REQ-014 mem_rdata  input  16  from mem_system DataOut.
REQ-015 mem_done  input  1  from mem_system Done.
REQ-016 mem_err  input  1  from mem_system err.
REQ-017 err  output  1  error indication.

Function
REQ-018 The FSM SHALL have states IDLE, GRANT_I, GRANT_D.
REQ-019 In IDLE with any request, the arbiter SHALL select one requester, latch its addr, wdata (0 for fetch) and op into registers, and move to GRANT_I/GRANT_D next edge.
REQ-020 In IDLE, mem_rd and mem_wr SHALL be 0.
REQ-021 In GRANT_x, mem_addr/mem_wdata SHALL come from latched registers, and mem_rd/mem_wr SHALL be held per latched op until mem_done.
REQ-022 On mem_done in GRANT_x, the arbiter SHALL pulse x_done, drive x_rdata = mem_rdata (0 for writes), and return to IDLE.
REQ-023 Minimum latency, request to done, SHALL be 1 cycle plus mem_system latency; a 0-cycle-delay mem_done (same cycle as first GRANT cycle) completes at request+1.
REQ-024 Back-to-back grants SHALL have one IDLE cycle between them.
REQ-025 Requester inputs SHALL be ignored while not granted; the latched copy alone drives memory.
REQ-026 Default priority (fixed) SHALL give d_req precedence over i_req on a tie.
REQ-027 x_stall SHALL equal x_req & ~x_done.
REQ-028 err SHALL be asserted combinationally when mem_err is high in GRANT_x.
REQ-029 err SHALL also be asserted for one cycle when the granted requester drops its req before done (protocol violation); the transaction still completes and its done pulse is still issued.
REQ-030 mem_done in IDLE SHALL be ignored and SHALL not assert err.
REQ-031 A requester re-asserting req in its own done cycle SHALL be seen as a new request in the following IDLE cycle.

Reset
REQ-032 On rst, state SHALL become IDLE, latched registers 0, and the round-robin pointer (if built) SHALL point to D.
REQ-033 During and right after rst, all outputs SHALL be 0 (done, rdata, stall outputs gated, mem_rd/mem_wr, err).
REQ-034 A reset mid-transaction SHALL abandon it with no done pulse; mem_system shares rst.

Configuration
REQ-035 Macro MEM_ARB_RR_EN defined: ties SHALL resolve round-robin: the requester not granted last wins, and the pointer updates at each grant.
REQ-036 MEM_ARB_RR_EN undefined: fixed D-over-I priority per REQ-026; no pointer register.

Verification
REQ-037 Fetch alone: i_req=1, i_addr=0x0040, mem_done 2 cycles after GRANT_I -> mem_rd=1, mem_addr=0x0040 held, i_done pulse with i_rdata=mem_rdata=0x1234, d_done=0.
REQ-038 Tie, fixed: i_req=d_req=1, d_wr=1, d_addr=0x0100, d_wdata=0xBEEF -> D served first (mem_wr=1, mem_wdata=0xBEEF), d_rdata=0; I served after one IDLE cycle; i_stall=1 throughout D.
REQ-039 Tie, MEM_ARB_RR_EN, both held for 4 transactions -> grant order D, I, D, I.
REQ-040 Reset in GRANT_D after 1 cycle -> next cycle IDLE, no d_done, mem_wr=0, all outputs 0.
REQ-041 Errors: mem_err=1 in GRANT_I -> err=1 that cycle; d_req dropped mid-GRANT_D -> err pulse 1 cycle, d_done still issued; mem_done in IDLE -> err=0, no done.
